// File: rtl/struct_stream_pkg.sv
// Shared types and record-generation formulas for the struct stream checker.
// Record widths depend on module parameters, so the record structs are declared in the modules.
package struct_stream_pkg;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        DONE,
        FAIL
    } state_t;

    // Channel c produces data = seed(c) + k*step(c), truncated to the data width.
    function automatic int unsigned chan_seed(input int unsigned c);
        return c << 4;
    endfunction

    function automatic int unsigned chan_step(input int unsigned c);
        return 2 * c + 1;
    endfunction

endpackage

// File: rtl/struct_fifo.sv
// DEPTH-entry FIFO for channel-tagged records; simultaneous read and write on a full FIFO is legal.
// Storage is not reset, only the pointers and occupancy.
module struct_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == OCC_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/struct_stream_checker.sv
// Round-robin record generators feed a FIFO; the consumer checks each popped record against
// an independent per-channel expected model and reports sticky success or fail.
module struct_stream_checker
    import struct_stream_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MODE_W    = 2,
    parameter int NUM_MODES = 3,
    parameter int CHANNELS  = 2,
    parameter int DEPTH     = 4,
    parameter int COUNT     = 16
) (
    input  logic                                             clock,
    input  logic                                             clear,
    input  logic                                             inject_error,
    output logic                                             success,
    output logic                                             fail,
    output logic [DATA_W-1:0]                                data_out,
    output logic [MODE_W-1:0]                                mode_out,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] chan_out,
    output logic [$clog2(CHANNELS*COUNT+1)-1:0]              checked
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int NCH   = 1 << CH_W;
    localparam int TOTAL = CHANNELS * COUNT;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0]  TOTAL_C   = CNT_W'(TOTAL);
    localparam logic [OCC_W-1:0]  DEPTH_C   = OCC_W'(DEPTH);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
    localparam logic [CH_W-1:0]   CHAN_LAST = CH_W'(CHANNELS - 1);

    typedef struct packed {
        logic [MODE_W-1:0] mode;
        logic [DATA_W-1:0] data;
    } record_t;

    typedef struct packed {
        logic [CH_W-1:0] chan;
        record_t         rec;
    } entry_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  writes_done;
    logic [CH_W-1:0]   rr;
    logic [DATA_W-1:0] gen_data [NCH];
    logic [MODE_W-1:0] gen_mode [NCH];
    logic [DATA_W-1:0] exp_data [NCH];
    logic [MODE_W-1:0] exp_mode [NCH];

    entry_t            wr_entry;
    entry_t            head;
    logic              wr_en;
    logic              rd_en;
    logic              full;
    logic              empty;
    logic              match;
    logic [OCC_W-1:0]  occ;

    struct_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .clear   (clear),
        .wr_en   (wr_en),
        .wr_data (wr_entry),
        .rd_en   (rd_en),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (occ)
    );

    // Generators write only while the FSM is live; a full FIFO still accepts when a read frees a slot.
    always_comb begin
        rd_en             = (state == RUN) && !empty;
        wr_en             = ((state == FILL) || (state == RUN)) && (writes_done != TOTAL_C)
                            && (!full || rd_en);
        wr_entry.chan     = rr;
        wr_entry.rec.mode = gen_mode[rr];
        wr_entry.rec.data = gen_data[rr] ^ DATA_W'(inject_error);
        match             = (head.rec.data == exp_data[head.chan])
                            && (head.rec.mode == exp_mode[head.chan]);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL: begin
                if (wr_en && ((occ + OCC_W'(1) == DEPTH_C)
                              || (writes_done + CNT_W'(1) == TOTAL_C))) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (rd_en) begin
                    if (!match) begin
                        state_nxt = FAIL;
                    end else if (checked + CNT_W'(1) == TOTAL_C) begin
                        state_nxt = DONE;
                    end
                end
            end
            default: state_nxt = state;
        endcase
    end

    assign success = (state == DONE);
    assign fail    = (state == FAIL);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= FILL;
            writes_done <= '0;
            rr          <= '0;
            checked     <= '0;
            data_out    <= '0;
            mode_out    <= '0;
            chan_out    <= '0;
            for (int c = 0; c < NCH; c++) begin
                gen_data[c] <= DATA_W'(chan_seed(c));
                gen_mode[c] <= '0;
                exp_data[c] <= DATA_W'(chan_seed(c));
                exp_mode[c] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (wr_en) begin
                writes_done  <= writes_done + CNT_W'(1);
                rr           <= (rr == CHAN_LAST) ? '0 : rr + CH_W'(1);
                gen_data[rr] <= gen_data[rr] + DATA_W'(chan_step(32'(rr)));
                gen_mode[rr] <= (gen_mode[rr] == MODE_LAST) ? '0 : gen_mode[rr] + MODE_W'(1);
            end
            // A mismatching record is still exposed, but only matching records count as checked.
            if (rd_en) begin
                data_out           <= head.rec.data;
                mode_out           <= head.rec.mode;
                chan_out           <= head.chan;
                exp_data[head.chan] <= exp_data[head.chan] + DATA_W'(chan_step(32'(head.chan)));
                exp_mode[head.chan] <= (exp_mode[head.chan] == MODE_LAST) ? '0
                                       : exp_mode[head.chan] + MODE_W'(1);
                if (match) begin
                    checked <= checked + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_struct_stream_checker.sv
// Bench for struct_stream_checker: three parameterisations run side by side against a
// record-log reference model, plus literal expectations for the documented sequences.
`timescale 1ns/1ps
module tb_struct_stream_checker;

    localparam int NI = 3;

    logic clock        = 1'b0;
    logic clear        = 1'b1;
    logic inject_error = 1'b0;

    always #5 clock = ~clock;

    logic       s0, f0;
    logic [7:0] d0;
    logic [1:0] m0;
    logic [0:0] c0;
    logic [5:0] k0;

    logic       s1, f1;
    logic [3:0] d1;
    logic [1:0] m1;
    logic [1:0] c1;
    logic [4:0] k1;

    logic       s2, f2;
    logic [7:0] d2;
    logic [1:0] m2;
    logic [0:0] c2;
    logic [0:0] k2;

    struct_stream_checker #(
        .DATA_W(8), .MODE_W(2), .NUM_MODES(3), .CHANNELS(2), .DEPTH(4), .COUNT(16)
    ) dut0 (
        .clock(clock), .clear(clear), .inject_error(inject_error),
        .success(s0), .fail(f0), .data_out(d0), .mode_out(m0), .chan_out(c0), .checked(k0)
    );

    struct_stream_checker #(
        .DATA_W(4), .MODE_W(2), .NUM_MODES(3), .CHANNELS(3), .DEPTH(2), .COUNT(8)
    ) dut1 (
        .clock(clock), .clear(clear), .inject_error(inject_error),
        .success(s1), .fail(f1), .data_out(d1), .mode_out(m1), .chan_out(c1), .checked(k1)
    );

    struct_stream_checker #(
        .DATA_W(8), .MODE_W(2), .NUM_MODES(3), .CHANNELS(1), .DEPTH(4), .COUNT(1)
    ) dut2 (
        .clock(clock), .clear(clear), .inject_error(inject_error),
        .success(s2), .fail(f2), .data_out(d2), .mode_out(m2), .chan_out(c2), .checked(k2)
    );

    int cfg_dw  [NI] = '{8, 4, 8};
    int cfg_nm  [NI] = '{3, 3, 3};
    int cfg_ch  [NI] = '{2, 3, 1};
    int cfg_dep [NI] = '{4, 2, 4};
    int cfg_cnt [NI] = '{16, 8, 1};

    // Reference model: a log of every record written, read back in order.
    int w_data [NI][64];
    int w_mode [NI][64];
    int w_ch   [NI][64];
    int m_wr   [NI];
    int m_rd   [NI];
    int m_run  [NI];
    int rk     [NI][4];
    int e_data [NI];
    int e_mode [NI];
    int e_chan [NI];
    int e_checked [NI];
    int e_succ [NI];
    int e_fail [NI];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int rec_data(input int i, input int c, input int k);
        return ((c * 16) + k * (2 * c + 1)) % (1 << cfg_dw[i]);
    endfunction

    function automatic int rec_mode(input int i, input int k);
        return k % cfg_nm[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_wr[i] = 0; m_rd[i] = 0; m_run[i] = 0;
            e_data[i] = 0; e_mode[i] = 0; e_chan[i] = 0;
            e_checked[i] = 0; e_succ[i] = 0; e_fail[i] = 0;
            for (int c = 0; c < 4; c++) rk[i][c] = 0;
        end
    endtask

    task automatic model_step(input int i, input logic inj);
        int  tot;
        int  occ;
        int  c;
        int  k;
        int  r;
        int  n;
        bit  rd;
        bit  wr;
        bit  ok;
        tot = cfg_ch[i] * cfg_cnt[i];
        if (e_succ[i] != 0 || e_fail[i] != 0) return;
        occ = m_wr[i] - m_rd[i];
        rd  = (m_run[i] != 0) && (occ > 0);
        wr  = (m_wr[i] < tot) && ((occ < cfg_dep[i]) || rd);
        if (rd) begin
            r  = m_rd[i];
            c  = w_ch[i][r];
            ok = (w_data[i][r] == rec_data(i, c, rk[i][c])) && (w_mode[i][r] == rec_mode(i, rk[i][c]));
            e_data[i] = w_data[i][r];
            e_mode[i] = w_mode[i][r];
            e_chan[i] = c;
            rk[i][c]++;
            m_rd[i]++;
            if (!ok) begin
                e_fail[i] = 1;
            end else begin
                e_checked[i]++;
                if (e_checked[i] == tot) e_succ[i] = 1;
            end
        end
        if (wr) begin
            n = m_wr[i];
            c = n % cfg_ch[i];
            k = n / cfg_ch[i];
            w_data[i][n] = rec_data(i, c, k) ^ (inj ? 1 : 0);
            w_mode[i][n] = rec_mode(i, k);
            w_ch[i][n]   = c;
            m_wr[i]++;
        end
        if (m_run[i] == 0 && ((m_wr[i] - m_rd[i] >= cfg_dep[i]) || (m_wr[i] == tot))) m_run[i] = 1;
    endtask

    always @(posedge clock or posedge clear) begin
        if (clear) begin
            model_reset();
        end else begin
            for (int i = 0; i < NI; i++) model_step(i, inject_error);
        end
    end

    task automatic chk(input string what, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", what, inst, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of every instance against the model.
    always @(negedge clock) begin
        logic [31:0] a_s, a_f, a_d, a_m, a_c, a_k;
        for (int i = 0; i < NI; i++) begin
            case (i)
                0:       begin a_s = 32'(s0); a_f = 32'(f0); a_d = 32'(d0); a_m = 32'(m0); a_c = 32'(c0); a_k = 32'(k0); end
                1:       begin a_s = 32'(s1); a_f = 32'(f1); a_d = 32'(d1); a_m = 32'(m1); a_c = 32'(c1); a_k = 32'(k1); end
                default: begin a_s = 32'(s2); a_f = 32'(f2); a_d = 32'(d2); a_m = 32'(m2); a_c = 32'(c2); a_k = 32'(k2); end
            endcase
            chk("success", i, a_s, e_succ[i]);
            chk("fail", i, a_f, e_fail[i]);
            chk("data_out", i, a_d, e_data[i]);
            chk("mode_out", i, a_m, e_mode[i]);
            chk("chan_out", i, a_c, e_chan[i]);
            chk("checked", i, a_k, e_checked[i]);
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic rec0(input string what, input int c, input int d, input int m, input int k);
        chk({what, " chan"}, 0, 32'(c0), c);
        chk({what, " data"}, 0, 32'(d0), d);
        chk({what, " mode"}, 0, 32'(m0), m);
        chk({what, " checked"}, 0, 32'(k0), k);
    endtask

    task automatic restart(input int hold);
        clear = 1'b1;
        repeat (hold) tick();
        clear = 1'b0;
    endtask

    initial begin
        // Directed run with default parameters and both corner configurations.
        repeat (3) tick();
        chk("reset success", 0, 32'(s0), 0);
        chk("reset checked", 0, 32'(k0), 0);
        clear = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            case (e)
                1:  chk("single success early", 2, 32'(s2), 0);
                2:  begin
                        chk("single success", 2, 32'(s2), 1);
                        chk("single checked", 2, 32'(k2), 1);
                    end
                4:  chk("no read in fill", 0, 32'(k0), 0);
                5:  rec0("read1", 0, 8'h00, 0, 1);
                6:  rec0("read2", 1, 8'h10, 0, 2);
                7:  rec0("read3", 0, 8'h01, 1, 3);
                8:  rec0("read4", 1, 8'h13, 1, 4);
                11: rec0("mode wrap", 0, 8'h03, 0, 7);
                17: begin
                        chk("ch2 chan", 1, 32'(c1), 2);
                        chk("ch2 wrapped data", 1, 32'(d1), 4);
                        chk("ch2 mode", 1, 32'(m1), 1);
                    end
                25: chk("small success early", 1, 32'(s1), 0);
                26: begin
                        chk("small success", 1, 32'(s1), 1);
                        chk("small checked", 1, 32'(k1), 24);
                        chk("small fail", 1, 32'(f1), 0);
                    end
                35: chk("success early", 0, 32'(s0), 0);
                36: begin
                        chk("success", 0, 32'(s0), 1);
                        chk("checked total", 0, 32'(k0), 32);
                        chk("fail clear", 0, 32'(f0), 0);
                    end
                default: ;
            endcase
        end

        // Single corrupted record on edge 6.
        restart(2);
        for (int e = 1; e <= 40; e++) begin
            inject_error = (e == 6);
            tick();
            case (e)
                9:  chk("fail early", 0, 32'(f0), 0);
                10: begin
                        chk("fail on bad read", 0, 32'(f0), 1);
                        chk("checked at fail", 0, 32'(k0), 5);
                        chk("bad data shown", 0, 32'(d0), 8'h17);
                    end
                40: begin
                        chk("fail sticky", 0, 32'(f0), 1);
                        chk("no success after fail", 0, 32'(s0), 0);
                    end
                default: ;
            endcase
        end
        inject_error = 1'b0;

        // Asynchronous clear in the middle of RUN.
        restart(2);
        repeat (12) tick();
        #1 clear = 1'b1;
        #1;
        chk("async clear checked", 0, 32'(k0), 0);
        chk("async clear data", 0, 32'(d0), 0);
        chk("async clear chan", 0, 32'(c0), 0);
        chk("async clear mode", 0, 32'(m0), 0);
        repeat (2) tick();
        clear = 1'b0;
        for (int e = 1; e <= 36; e++) begin
            tick();
            if (e == 35) chk("restart success early", 0, 32'(s0), 0);
            if (e == 36) chk("restart success", 0, 32'(s0), 1);
        end

        // Randomised runs: sporadic injections and mid-cycle clears.
        for (int it = 0; it < 20; it++) begin
            restart(int'($urandom_range(1, 2)));
            for (int e = 0; e < int'($urandom_range(10, 60)); e++) begin
                inject_error = ($urandom_range(0, 39) == 0);
                tick();
            end
            inject_error = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                #($urandom_range(0, 2));
                clear = 1'b1;
                tick();
            end
        end
        clear = 1'b0;
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, %0d checks made", n_checks);
        $fatal(1, "timeout");
    end

endmodule
